// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave with an 8-bit transmit holding register.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   spi_clk, mosi, cs SPI master signals (asynchronous to clk, cs active low)
//   miso              serial data to master, MSB first (0 while idle)
//   tx_data/tx_valid  next byte to transmit; accepted when tx_ready is high
//   tx_ready          holding register empty
//   rx_data/rx_valid  last complete received byte; rx_valid pulses once per byte
//   tx_underrun       one-cycle pulse when FILL_BYTE is loaded for lack of data
//   busy              transaction active (synchronized cs low)
module spi_slave #(
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_next;

  // [0],[1] form the synchronizer, [2] is the edge-history flop.
  logic [2:0]  sclk_sr;
  logic [2:0]  cs_sr;
  logic [2:0]  mosi_sr;

  logic [7:0]  tx_shift;
  logic [7:0]  rx_shift;
  logic [7:0]  hold;
  logic        hold_valid;
  logic [2:0]  bit_cnt;

  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic        in_active, load, accept;
  logic [7:0]  rx_next;

  // mosi is taken from its history stage: it is one cycle older than the
  // spi_clk sample that flags the edge, well inside the mosi stability window.
  always_comb begin
    sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    cs_fall   = ~cs_sr[1] & cs_sr[2];
    cs_rise   = cs_sr[1] & ~cs_sr[2];
    in_active = (state == ACTIVE) && !cs_rise;
    load      = ((state == IDLE) && cs_fall) ||
                (in_active && sclk_fall && (bit_cnt == 3'd0));
    accept    = tx_valid && !hold_valid;
    rx_next   = {rx_shift[6:0], mosi_sr[2]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE:  if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (state == ACTIVE);
    miso     = (state == ACTIVE) ? tx_shift[7] : 1'b0;
    tx_ready = !hold_valid;
  end

  // Synchronizers
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sr <= '0;
      cs_sr   <= '1;
      mosi_sr <= '0;
    end else begin
      sclk_sr <= {sclk_sr[1:0], spi_clk};
      cs_sr   <= {cs_sr[1:0], cs};
      mosi_sr <= {mosi_sr[1:0], mosi};
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (load) begin
        tx_shift    <= hold_valid ? hold : FILL_BYTE;
        tx_underrun <= !hold_valid;
      end else if (in_active && sclk_fall) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      // A byte accepted in the same cycle as an empty-holding load is kept
      // for the following byte; accept can only fire while holding is empty.
      if (load && hold_valid) begin
        hold_valid <= 1'b0;
      end else if (accept) begin
        hold       <= tx_data;
        hold_valid <= 1'b1;
      end

      if ((state == ACTIVE) && cs_rise) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (in_active && sclk_rise) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave (mode-0 master model, 50 ns
// SPI half period against a 10 ns system clock).
module tb_spi_slave;

  localparam int H = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_clk;
  logic       mosi;
  logic       cs;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int ur_cnt = 0;
  int rx0, ur0;
  logic [7:0] mi;

  spi_slave #(.FILL_BYTE(8'h00)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .mosi(mosi), .cs(cs),
    .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid)    rx_cnt++;
    if (tx_underrun) ur_cnt++;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clocks nbits bits out of mo MSB first; returns the miso bits sampled at
  // each rising edge. Leaves spi_clk low.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mo_in);
    mo_in = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      #H;
      spi_clk = 1'b1;
      mo_in[7-i] = miso;
      #H;
      spi_clk = 1'b0;
    end
  endtask

  task automatic offer(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    #10;
    tx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; spi_clk = 1'b0; mosi = 1'b0; cs = 1'b1;
    tx_data = '0; tx_valid = 1'b0;
    #30;
    chk("rst_miso", {7'd0, miso}, 8'h00);
    chk("rst_tx_ready", {7'd0, tx_ready}, 8'h01);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("rst_underrun", {7'd0, tx_underrun}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    reset = 1'b0;
    #20;

    // Holding 3C, master sends A5
    offer(8'h3C);
    chk("t1_ready_full", {7'd0, tx_ready}, 8'h00);
    rx0 = rx_cnt; ur0 = ur_cnt;
    cs = 1'b0; #H;
    chk("t1_busy", {7'd0, busy}, 8'h01);
    chk("t1_ready_after_load", {7'd0, tx_ready}, 8'h01);
    chk("t1_no_underrun", ur_cnt - ur0, 8'h00);
    xfer(8'hA5, 8, mi);
    cs = 1'b1; #H;
    chk("t1_miso", mi, 8'h3C);
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_rx_pulses", rx_cnt - rx0, 8'h01);
    chk("t1_idle_busy", {7'd0, busy}, 8'h00);
    chk("t1_idle_miso", {7'd0, miso}, 8'h00);

    // Holding empty, master sends 0F
    rx0 = rx_cnt; ur0 = ur_cnt;
    cs = 1'b0; #H;
    chk("t2_underrun_at_cs", ur_cnt - ur0, 8'h01);
    xfer(8'h0F, 8, mi);
    cs = 1'b1; #H;
    chk("t2_miso", mi, 8'h00);
    chk("t2_rx_data", rx_data, 8'h0F);

    // Back-to-back bytes with cs held low
    offer(8'h56);
    rx0 = rx_cnt;
    cs = 1'b0; #H;
    chk("t3_ready_rise", {7'd0, tx_ready}, 8'h01);
    offer(8'h78);
    xfer(8'h12, 8, mi);
    chk("t3_miso0", mi, 8'h56);
    chk("t3_rx_data0", rx_data, 8'h12);
    xfer(8'h34, 8, mi);
    cs = 1'b1; #H;
    chk("t3_miso1", mi, 8'h78);
    chk("t3_rx_data1", rx_data, 8'h34);
    chk("t3_rx_pulses", rx_cnt - rx0, 8'h02);

    // Abort after 5 bits, then a full FF transfer
    rx0 = rx_cnt;
    cs = 1'b0; #H;
    xfer(8'hAA, 5, mi);
    cs = 1'b1; #H;
    chk("t4_partial_no_valid", rx_cnt - rx0, 8'h00);
    chk("t4_rx_kept", rx_data, 8'h34);
    chk("t4_busy_off", {7'd0, busy}, 8'h00);
    cs = 1'b0; #H;
    xfer(8'hFF, 8, mi);
    cs = 1'b1; #H;
    chk("t4_rx_data", rx_data, 8'hFF);
    chk("t4_rx_pulses", rx_cnt - rx0, 8'h01);

    // tx_valid while holding full is ignored
    offer(8'hC7);
    chk("t6_ready_full", {7'd0, tx_ready}, 8'h00);
    offer(8'h99);
    cs = 1'b0; #H;
    chk("t6_ready_after_load", {7'd0, tx_ready}, 8'h01);
    xfer(8'h00, 8, mi);
    cs = 1'b1; #H;
    chk("t6_miso", mi, 8'hC7);

    // Reset mid-transaction after 4 bits of C3
    cs = 1'b0; #H;
    xfer(8'hC3, 4, mi);
    offer(8'h5A);
    reset = 1'b1;
    #10;
    chk("t5_miso", {7'd0, miso}, 8'h00);
    chk("t5_tx_ready", {7'd0, tx_ready}, 8'h01);
    chk("t5_rx_data", rx_data, 8'h00);
    chk("t5_rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("t5_underrun", {7'd0, tx_underrun}, 8'h00);
    chk("t5_busy", {7'd0, busy}, 8'h00);
    reset = 1'b0; cs = 1'b1;
    rx0 = rx_cnt; ur0 = ur_cnt;
    #10;
    chk("t5_after_rx_valid", {7'd0, rx_valid}, 8'h00);
    chk("t5_after_underrun", {7'd0, tx_underrun}, 8'h00);
    #H;
    cs = 1'b0; #H;
    xfer(8'h81, 8, mi);
    cs = 1'b1; #H;
    chk("t5_rx_data_81", rx_data, 8'h81);
    chk("t5_rx_pulses", rx_cnt - rx0, 8'h01);
    chk("t5_fill_miso", mi, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
